// File: rtl/seg_scan_drv.sv
`timescale 1ns/1ps
// seg_scan_drv: time-multiplexed 4-digit common-anode 7-segment driver with frame-coherent
// snapshot, per-digit blink and colon dp. Define SEG_LZB_EN for leading-zero blanking of digits 3:2.
module seg_scan_drv #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int SCAN_HZ      = 4000,
   parameter int BLINK_FRAMES = 250,
   parameter int DEAD_CYC     = 16
) (
   input  logic       Clk,
   input  logic       CR,
   input  logic [7:0] LED_H,
   input  logic [7:0] LED_L,
   input  logic       dp_in,
   input  logic [3:0] blink_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp_out
);

   localparam int STEP_CYC = CLK_HZ / SCAN_HZ;
   localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam int FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
   localparam logic [STEP_W-1:0] DEAD_END  = STEP_W'(DEAD_CYC);
   localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

   logic [STEP_W-1:0] step_q, step_d;
   logic [1:0]        idx_q, idx_d;
   logic [15:0]       snap_q, snap_d;
   logic              phase_q, phase_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              step_wrap;
   logic              frame_end;
   logic [3:0]        nib;
   logic              blank;
   logic              lzb;

   // Nibbles A-F render as a dash so a bad upstream code is visible on the display.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
      case (n)
         4'd0:    bcd_to_seg = 7'h40;
         4'd1:    bcd_to_seg = 7'h79;
         4'd2:    bcd_to_seg = 7'h24;
         4'd3:    bcd_to_seg = 7'h30;
         4'd4:    bcd_to_seg = 7'h19;
         4'd5:    bcd_to_seg = 7'h12;
         4'd6:    bcd_to_seg = 7'h02;
         4'd7:    bcd_to_seg = 7'h78;
         4'd8:    bcd_to_seg = 7'h00;
         4'd9:    bcd_to_seg = 7'h10;
         default: bcd_to_seg = 7'h3F;
      endcase
   endfunction

   always_comb begin
      step_wrap = (step_q == STEP_LAST);
      frame_end = step_wrap && (idx_q == 2'd3);
      step_d    = step_wrap ? '0 : step_q + 1'b1;
      idx_d     = step_wrap ? idx_q + 2'd1 : idx_q;
      snap_d    = frame_end ? {LED_H, LED_L} : snap_q;
      frm_d     = frm_q;
      phase_d   = phase_q;
      if (frame_end) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d   = frm_q + 1'b1;
         end
      end
   end

   // Pin values are derived from the current scan state, so pins trail the state by one clock.
   always_comb begin
      case (idx_q)
         2'd0:    nib = snap_q[3:0];
         2'd1:    nib = snap_q[7:4];
         2'd2:    nib = snap_q[11:8];
         default: nib = snap_q[15:12];
      endcase
      blank = ~phase_q & blink_mask[idx_q];
      lzb   = 1'b0;
`ifdef SEG_LZB_EN
      if (idx_q == 2'd3)
         lzb = (snap_q[15:12] == 4'h0);
      else if (idx_q == 2'd2)
         lzb = (snap_q[15:8] == 8'h00);
`endif
      seg_d = (blank | lzb) ? 7'h7F : bcd_to_seg(nib);
      dp_d  = ((idx_q == 2'd2) && !blank) ? ~dp_in : 1'b1;
      an_d  = (step_q < DEAD_END) ? 4'hF : ~(4'b0001 << idx_q);
   end

   always_ff @(posedge Clk or posedge CR) begin
      if (CR) begin
         step_q  <= '0;
         idx_q   <= 2'd0;
         snap_q  <= 16'h0000;
         phase_q <= 1'b1;
         frm_q   <= '0;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         step_q  <= step_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         phase_q <= phase_d;
         frm_q   <= frm_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an     = an_q;
   assign seg    = seg_q;
   assign dp_out = dp_q;

endmodule
